ex_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline, directly downstream of decode.
//  - Latches decode outputs (aluop, alusel, reg1, reg2, wd, wreg) in an internal ID/EX register.
//  - Computes the logic, shift and move result and drives it combinationally to the EX/MEM

---
 rtl/ex_stage_pkg.sv | 53 +++++
 rtl/ex_alu.sv | 52 +++++
 rtl/ex_stage.sv | 71 +++++++
 tb/tb_ex_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Execute stage shared definitions: opcodes, result classes,
// widths and the ID/EX bundle.
package ex_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  localparam logic [DATA_W-1:0] ZeroWord   = '0;
  localparam logic [REG_AW-1:0] NOPRegAddr = '0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_MOVZ_OP = 8'b0000_1010;
  localparam logic [ALUOP_W-1:0] EXE_MOVN_OP = 8'b0000_1011;
  localparam logic [ALUOP_W-1:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] EXE_MTLO_OP = 8'b0001_0011;

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'b011;

  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [DATA_W-1:0]   reg1;
    logic [DATA_W-1:0]   reg2;
    logic [REG_AW-1:0]   wd;
    logic                wreg;
  } id_ex_t;

  localparam id_ex_t IdExBubble = '{
    aluop:  EXE_NOP_OP,
    alusel: EXE_RES_NOP,
    reg1:   ZeroWord,
    reg2:   ZeroWord,
    wd:     NOPRegAddr,
    wreg:   WriteDisable
  };

endpackage

// File: rtl/ex_alu.sv
// Execute result mux: logic, shift and move results
// selected by the latched result class.
module ex_alu
  import ex_stage_pkg::*;
(
  input  logic [ALUOP_W-1:0]  aluop,
  input  logic [ALUSEL_W-1:0] alusel,
  input  logic [DATA_W-1:0]   r1,
  input  logic [DATA_W-1:0]   r2,
  input  logic [DATA_W-1:0]   hi,
  input  logic [DATA_W-1:0]   lo,
  output logic [DATA_W-1:0]   result
);

  logic [4:0] sh;
  assign sh = r1[4:0];

  // Pick the result by class, then by operation
  always_comb begin
    result = ZeroWord;
    unique case (1'b1)
      (alusel == EXE_RES_LOGIC): begin
        unique case (1'b1)
          (aluop == EXE_OR_OP):  result = r1 | r2;
          (aluop == EXE_AND_OP): result = r1 & r2;
          (aluop == EXE_XOR_OP): result = r1 ^ r2;
          (aluop == EXE_NOR_OP): result = ~(r1 | r2);
          default:               result = ZeroWord;
        endcase
      end
      (alusel == EXE_RES_SHIFT): begin
        unique case (1'b1)
          (aluop == EXE_SLL_OP): result = r2 << sh;
          (aluop == EXE_SRL_OP): result = r2 >> sh;
          (aluop == EXE_SRA_OP): result = $signed(r2) >>> sh;
          default:               result = ZeroWord;
        endcase
      end
      (alusel == EXE_RES_MOVE): begin
        unique case (1'b1)
          (aluop == EXE_MFHI_OP): result = hi;
          (aluop == EXE_MFLO_OP): result = lo;
          (aluop == EXE_MOVN_OP): result = r1;
          (aluop == EXE_MOVZ_OP): result = r1;
          default:                result = ZeroWord;
        endcase
      end
      default: result = ZeroWord;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, HI/LO registers and the
// combinational result feeding EX/MEM and decode forwarding.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [ALUOP_W-1:0]  aluop_i,
  input  logic [ALUSEL_W-1:0] alusel_i,
  input  logic [DATA_W-1:0]   reg1_i,
  input  logic [DATA_W-1:0]   reg2_i,
  input  logic [REG_AW-1:0]   wd_i,
  input  logic                wreg_i,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);

  id_ex_t            id_ex;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // ID/EX register: flush beats stall, stall holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex <= IdExBubble;
    end else if (flush_i) begin
      id_ex <= IdExBubble;
    end else if (!stall_i) begin
      id_ex <= '{
        aluop:  aluop_i,
        alusel: alusel_i,
        reg1:   reg1_i,
        reg2:   reg2_i,
        wd:     wd_i,
        wreg:   wreg_i
      };
    end
  end

  // HI/LO write only on the cycle the EX slot advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= ZeroWord;
      lo <= ZeroWord;
    end else if (!stall_i) begin
      if (id_ex.aluop == EXE_MTHI_OP) hi <= id_ex.reg1;
      if (id_ex.aluop == EXE_MTLO_OP) lo <= id_ex.reg1;
    end
  end

  ex_alu u_alu (
    .aluop  (id_ex.aluop),
    .alusel (id_ex.alusel),
    .r1     (id_ex.reg1),
    .r2     (id_ex.reg2),
    .hi     (hi),
    .lo     (lo),
    .result (wdata_o)
  );

  assign wd_o   = id_ex.wd;
  assign wreg_o = id_ex.wreg;
  assign hi_o   = hi;
  assign lo_o   = lo;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with an expected-result
// queue filled at drive time and drained at output time.
module tb_ex_stage;
  import ex_stage_pkg::*;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int vectors;
  int miscompares;
  exp_t sb[$];

  ex_stage dut (
    .clk      (clk),
    .rst      (rst),
    .stall_i  (stall_i),
    .flush_i  (flush_i),
    .aluop_i  (aluop_i),
    .alusel_i (alusel_i),
    .reg1_i   (reg1_i),
    .reg2_i   (reg2_i),
    .wd_i     (wd_i),
    .wreg_i   (wreg_i),
    .wd_o     (wd_o),
    .wreg_o   (wreg_o),
    .wdata_o  (wdata_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op,
                       input logic [2:0] sel,
                       input logic [31:0] r1,
                       input logic [31:0] r2,
                       input logic [4:0] wd,
                       input logic wr,
                       input logic st,
                       input logic fl);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = r1;
    reg2_i   = r2;
    wd_i     = wd;
    wreg_i   = wr;
    stall_i  = st;
    flush_i  = fl;
  endtask

  // Drive, queue the expectation, clock once, check outputs
  task automatic step(input string tag,
                      input logic [7:0] op,
                      input logic [2:0] sel,
                      input logic [31:0] r1,
                      input logic [31:0] r2,
                      input logic [4:0] wd,
                      input logic wr,
                      input logic st,
                      input logic fl,
                      input logic [4:0] e_wd,
                      input logic e_wr,
                      input logic [31:0] e_data);
    exp_t e;
    exp_t got;
    drive(op, sel, r1, r2, wd, wr, st, fl);
    e.wd    = e_wd;
    e.wreg  = e_wr;
    e.wdata = e_data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      chk({tag, ".wd"}, {27'd0, wd_o}, {27'd0, got.wd});
      chk({tag, ".wreg"}, {31'd0, wreg_o}, {31'd0, got.wreg});
      chk({tag, ".wdata"}, wdata_o, got.wdata);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    rst = 1'b0;
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h1234_5678, 32'h9abc_def0,
          5'd7, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst.wd", {27'd0, wd_o}, 32'd0);
    chk("rst.wdata", wdata_o, 32'd0);
    chk("rst.hi", hi_o, 32'd0);
    chk("rst.lo", lo_o, 32'd0);

    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0,
          1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rel.wreg", {31'd0, wreg_o}, 32'd0);
    chk("rel.wdata", wdata_o, 32'd0);

    step("or", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_1100,
         32'h0000_0020, 5'd1, 1'b1, 1'b0, 1'b0,
         5'd1, 1'b1, 32'h0000_1120);
    step("nor", EXE_NOR_OP, EXE_RES_LOGIC, 32'd0, 32'd0,
         5'd2, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 32'hFFFF_FFFF);
    step("and", EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234,
         32'h0FF0_FF00, 5'd3, 1'b1, 1'b0, 1'b0,
         5'd3, 1'b1, 32'h00F0_1200);
    step("xor", EXE_XOR_OP, EXE_RES_LOGIC, 32'hF0F0_1234,
         32'h0FF0_FF00, 5'd4, 1'b1, 1'b0, 1'b0,
         5'd4, 1'b1, 32'hFF00_ED34);
    step("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4,
         32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0,
         5'd5, 1'b1, 32'hF800_0000);
    step("srl", EXE_SRL_OP, EXE_RES_SHIFT, 32'd4,
         32'h8000_0000, 5'd6, 1'b1, 1'b0, 1'b0,
         5'd6, 1'b1, 32'h0800_0000);
    step("sll", EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0021,
         32'd1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 32'h2);
    step("movn", EXE_MOVN_OP, EXE_RES_MOVE, 32'hABCD_0123,
         32'd0, 5'd8, 1'b1, 1'b0, 1'b0,
         5'd8, 1'b1, 32'hABCD_0123);
    step("unk", EXE_OR_OP, 3'b111, 32'hFFFF_FFFF,
         32'hFFFF_FFFF, 5'd9, 1'b1, 1'b0, 1'b0,
         5'd9, 1'b1, 32'd0);

    step("mthi", EXE_MTHI_OP, EXE_RES_NOP, 32'hDEAD_BEEF,
         32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("mthi.hi_pre", hi_o, 32'd0);
    step("mfhi", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0,
         5'd10, 1'b1, 1'b0, 1'b0, 5'd10, 1'b1, 32'hDEAD_BEEF);
    chk("mfhi.hi", hi_o, 32'hDEAD_BEEF);

    step("mtlo", EXE_MTLO_OP, EXE_RES_NOP, 32'd5, 32'd0,
         5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("mtlo.lo_pre", lo_o, 32'd0);
    step("nop1", EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0,
         5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("mtlo.lo", lo_o, 32'd5);

    step("mthi7", EXE_MTHI_OP, EXE_RES_NOP, 32'd7, 32'd0,
         5'd11, 1'b0, 1'b0, 1'b0, 5'd11, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step("stall", EXE_OR_OP, EXE_RES_LOGIC, 32'h55, 32'hAA,
           5'd12, 1'b1, 1'b1, 1'b0, 5'd11, 1'b0, 32'd0);
      chk("stall.hi", hi_o, 32'hDEAD_BEEF);
    end
    step("mfhi7", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0,
         5'd13, 1'b1, 1'b0, 1'b0, 5'd13, 1'b1, 32'd7);
    chk("mfhi7.hi", hi_o, 32'd7);

    step("or2", EXE_OR_OP, EXE_RES_LOGIC, 32'hF0, 32'h0F,
         5'd14, 1'b1, 1'b0, 1'b0, 5'd14, 1'b1, 32'hFF);
    step("flush_stall", EXE_OR_OP, EXE_RES_LOGIC, 32'h1, 32'h2,
         5'd15, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0);

    step("mtlo_fl", EXE_MTLO_OP, EXE_RES_NOP, 32'd9, 32'd0,
         5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0);
    step("nop2", EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0,
         5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("mtlo_fl.lo", lo_o, 32'd5);
    step("mflo", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0,
         5'd16, 1'b1, 1'b0, 1'b0, 5'd16, 1'b1, 32'd5);

    step("or3", EXE_OR_OP, EXE_RES_LOGIC, 32'h100, 32'h1,
         5'd17, 1'b1, 1'b0, 1'b0, 5'd17, 1'b1, 32'h101);
    stall_i = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid.wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_mid.wd", {27'd0, wd_o}, 32'd0);
    chk("rst_mid.wdata", wdata_o, 32'd0);
    chk("rst_mid.hi", hi_o, 32'd0);
    chk("rst_mid.lo", lo_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("post_rst", EXE_XOR_OP, EXE_RES_LOGIC, 32'hFF, 32'h0F,
         5'd18, 1'b1, 1'b0, 1'b0, 5'd18, 1'b1, 32'hF0);

    chk("sb.empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
